// File: rtl/spu_op_scheduler.sv
// spu_op_scheduler: round-robin arbiter that time-shares one SPU operation
// datapath between NUM_REQ requesters. It latches the winning packet onto
// the operand bus, waits the fixed datapath latency, and returns the result
// tagged with the owner's ID.
module spu_op_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int DP_LATENCY = 2,
    parameter int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [16*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [3:0]              dp_a,
    output logic [3:0]              dp_b,
    output logic [2:0]              dp_c,
    output logic [2:0]              dp_d,
    output logic [1:0]              dp_opsel,
    output logic                    dp_issue,
    input  logic [7:0]              dp_result,
    output logic                    rsp_valid,
    output logic [7:0]              rsp_data,
    output logic [ID_W-1:0]         rsp_id,
    input  logic                    rsp_ready,
    output logic                    busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state;
    logic [ID_W-1:0] ptr;
    logic [3:0]      cnt;

    logic            grant_vld;
    logic [ID_W-1:0] grant_idx;
    logic [15:0]     pkt;

    // Requester index reached k steps above the pointer, wrapping at NUM_REQ.
    function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base, input int k);
        logic [ID_W:0] sum;
        sum = {1'b0, base} + (ID_W+1)'(k);
        if (sum >= (ID_W+1)'(NUM_REQ))
            sum = sum - (ID_W+1)'(NUM_REQ);
        return sum[ID_W-1:0];
    endfunction

    // Pick the first valid requester at or above ptr; ready only in IDLE.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        req_ready = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_vld && req_valid[rr_idx(ptr, k)]) begin
                grant_vld = 1'b1;
                grant_idx = rr_idx(ptr, k);
            end
        end
        if (state == IDLE && grant_vld)
            req_ready[grant_idx] = 1'b1;
    end

    assign pkt = req_data[16*grant_idx +: 16];

    // Operation FSM; every output except req_ready is a register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            cnt       <= '0;
            dp_a      <= '0;
            dp_b      <= '0;
            dp_c      <= '0;
            dp_d      <= '0;
            dp_opsel  <= '0;
            dp_issue  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // grant_vld in IDLE is exactly a valid&ready transfer
                    if (grant_vld) begin
                        dp_a     <= pkt[3:0];
                        dp_b     <= pkt[7:4];
                        dp_c     <= pkt[10:8];
                        dp_d     <= pkt[13:11];
                        dp_opsel <= pkt[15:14];
                        rsp_id   <= grant_idx;
                        dp_issue <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    dp_issue <= 1'b0;
                    cnt      <= 4'(DP_LATENCY);
                    state    <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    // cnt==1 marks the cycle where dp_result is valid
                    if (cnt <= 4'd1) begin
                        rsp_data  <= dp_result;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    // rsp_* hold until the consumer takes the response
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        ptr       <= (rsp_id == ID_W'(NUM_REQ-1)) ? '0 : rsp_id + ID_W'(1);
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spu_op_scheduler.sv
// Directed bench for spu_op_scheduler: default instance with a 2-cycle
// {B,A} stub datapath, plus a DP_LATENCY=5 instance fed a cycle-count result.
module tb_spu_op_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [3:0]  req_valid;
    logic [63:0] req_data;
    logic [3:0]  req_ready;
    logic [3:0]  dp_a, dp_b;
    logic [2:0]  dp_c, dp_d;
    logic [1:0]  dp_opsel;
    logic        dp_issue;
    logic [7:0]  dp_result;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic [1:0]  rsp_id;
    logic        rsp_ready;
    logic        busy;

    logic [3:0]  req_valid5;
    logic [3:0]  req_ready5;
    logic [3:0]  dp_a5, dp_b5;
    logic [2:0]  dp_c5, dp_d5;
    logic [1:0]  dp_opsel5;
    logic        dp_issue5;
    logic [7:0]  dp_result5;
    logic        rsp_valid5;
    logic [7:0]  rsp_data5;
    logic [1:0]  rsp_id5;
    logic        rsp_ready5;
    logic        busy5;

    logic [7:0]  p1 = '0, p2 = '0;
    logic [31:0] cyc = '0;
    logic [31:0] t0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        p1  <= {dp_b, dp_a};
        p2  <= p1;
        cyc <= cyc + 1;
    end
    assign dp_result  = p2;
    assign dp_result5 = cyc[7:0];

    spu_op_scheduler u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .dp_a(dp_a), .dp_b(dp_b), .dp_c(dp_c), .dp_d(dp_d),
        .dp_opsel(dp_opsel), .dp_issue(dp_issue), .dp_result(dp_result),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id),
        .rsp_ready(rsp_ready), .busy(busy)
    );

    spu_op_scheduler #(.NUM_REQ(4), .DP_LATENCY(5)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid5), .req_data(req_data),
        .req_ready(req_ready5), .dp_a(dp_a5), .dp_b(dp_b5), .dp_c(dp_c5), .dp_d(dp_d5),
        .dp_opsel(dp_opsel5), .dp_issue(dp_issue5), .dp_result(dp_result5),
        .rsp_valid(rsp_valid5), .rsp_data(rsp_data5), .rsp_id(rsp_id5),
        .rsp_ready(rsp_ready5), .busy(busy5)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_dp_a"},      32'(dp_a), 0);
        chk({tag, "_dp_b"},      32'(dp_b), 0);
        chk({tag, "_dp_c"},      32'(dp_c), 0);
        chk({tag, "_dp_d"},      32'(dp_d), 0);
        chk({tag, "_dp_opsel"},  32'(dp_opsel), 0);
        chk({tag, "_dp_issue"},  32'(dp_issue), 0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        chk({tag, "_rsp_data"},  32'(rsp_data), 0);
        chk({tag, "_rsp_id"},    32'(rsp_id), 0);
        chk({tag, "_busy"},      32'(busy), 0);
        chk({tag, "_req_ready"}, 32'(req_ready), 0);
    endtask

    initial begin
        // requester i: A=i+1, B=i+8, C=i, D=7-i, OpSel=i
        for (int i = 0; i < 4; i++)
            req_data[16*i +: 16] = {2'(i), 3'(7-i), 3'(i), 4'(i+8), 4'(i+1)};
        rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0;
        req_valid5 = '0; rsp_ready5 = 1'b1;

        // reset state
        #3;
        chk_all_zero("reset");
        step(); step();
        rst_n = 1'b1;
        step();

        // single request from requester 2 with A=3, B=5
        req_data[32 +: 16] = {2'd1, 3'd2, 3'd4, 4'd5, 4'd3};
        req_valid = 4'b0100;
        #1;
        chk("single_ready", 32'(req_ready), 32'h4);
        chk("single_busy_idle", 32'(busy), 0);
        step(); req_valid = '0; #1;
        chk("single_issue", 32'(dp_issue), 1);
        chk("single_dp_a", 32'(dp_a), 3);
        chk("single_dp_b", 32'(dp_b), 5);
        chk("single_dp_c", 32'(dp_c), 4);
        chk("single_dp_d", 32'(dp_d), 2);
        chk("single_opsel", 32'(dp_opsel), 1);
        chk("single_busy", 32'(busy), 1);
        step();
        chk("single_issue_off", 32'(dp_issue), 0);
        chk("single_rv_t2", 32'(rsp_valid), 0);
        step();
        chk("single_rv_t3", 32'(rsp_valid), 0);
        step();
        chk("single_rv_t4", 32'(rsp_valid), 1);
        chk("single_data", 32'(rsp_data), 32'h53);
        chk("single_id", 32'(rsp_id), 2);
        rsp_ready = 1'b1;
        step();
        chk("single_rv_done", 32'(rsp_valid), 0);
        chk("single_busy_done", 32'(busy), 0);
        chk("single_hold_a", 32'(dp_a), 3);

        // all four continuously valid from a fresh pointer
        rst_n = 1'b0; #1; rst_n = 1'b1;
        req_data[32 +: 16] = {2'd2, 3'd5, 3'd2, 4'd10, 4'd3};
        req_valid = 4'hf;
        #1;
        for (int g = 0; g < 5; g++) begin
            chk("rr_ready", 32'(req_ready), 32'(1) << (g % 4));
            step(); step(); step();
            chk("rr_rv_early", 32'(rsp_valid), 0);
            step();
            chk("rr_rv", 32'(rsp_valid), 1);
            chk("rr_id", 32'(rsp_id), 32'(g % 4));
            chk("rr_data", 32'(rsp_data), 32'((((g % 4) + 8) << 4) | ((g % 4) + 1)));
            step();
        end
        req_valid = '0; rsp_ready = 1'b0;

        // backpressure: requester 3 served, requester 1 stalls behind it
        req_valid = 4'b1000;
        #1;
        chk("bp_ready3", 32'(req_ready), 32'h8);
        step(); req_valid = 4'b1010; #1;
        chk("bp_stall_issue", 32'(req_ready), 0);
        step(); step(); step();
        for (int k = 0; k < 6; k++) begin
            chk("bp_rv", 32'(rsp_valid), 1);
            chk("bp_data", 32'(rsp_data), 32'hB4);
            chk("bp_id", 32'(rsp_id), 3);
            chk("bp_stall", 32'(req_ready), 0);
            step();
        end
        rsp_ready = 1'b1; #1;
        chk("bp_stall_hs", 32'(req_ready), 0);
        step();
        chk("bp_accept1", 32'(req_ready), 32'h2);
        step(); req_valid = '0; #1;
        chk("bp_issue1", 32'(dp_issue), 1);
        step(); step(); step();
        chk("bp_rv1", 32'(rsp_valid), 1);
        chk("bp_id1", 32'(rsp_id), 1);
        chk("bp_data1", 32'(rsp_data), 32'h92);
        step();

        // reset during WAIT aborts the operation
        req_valid = 4'b0001;
        #1;
        chk("rst_ready0", 32'(req_ready), 32'h1);
        step(); req_valid = '0;
        step();
        rst_n = 1'b0; #1;
        chk_all_zero("midrst");
        step(); rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("midrst_no_rsp", 32'(rsp_valid), 0);
            chk("midrst_idle", 32'(busy), 0);
        end
        req_valid = 4'b1010;
        #1;
        chk("midrst_rr_restart", 32'(req_ready), 32'h2);

        // requester 0 pulses valid while busy and withdraws
        step(); req_valid = '0;
        step(); req_valid = 4'b0001; #1;
        chk("drop_stall", 32'(req_ready), 0);
        step(); req_valid = '0;
        step();
        chk("drop_rv", 32'(rsp_valid), 1);
        chk("drop_id", 32'(rsp_id), 1);
        for (int k = 0; k < 6; k++) begin
            step();
            chk("drop_no_grant", 32'(req_ready), 0);
            chk("drop_idle", 32'(busy), 0);
            chk("drop_no_rsp", 32'(rsp_valid), 0);
        end

        // DP_LATENCY=5: capture the result present in cycle T+6
        req_valid5 = 4'b0100;
        #1;
        chk("lat5_ready", 32'(req_ready5), 32'h4);
        t0 = cyc;
        step(); req_valid5 = '0; #1;
        chk("lat5_issue", 32'(dp_issue5), 1);
        repeat (5) step();
        chk("lat5_rv_t6", 32'(rsp_valid5), 0);
        step();
        chk("lat5_rv_t7", 32'(rsp_valid5), 1);
        chk("lat5_data", 32'(rsp_data5), (t0 + 6) & 32'hff);
        chk("lat5_id", 32'(rsp_id5), 2);
        step();
        chk("lat5_done", 32'(busy5), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
